// File: rtl/ibex_obi_axi_bridge.sv
// Bridge from the Ibex OBI data port to a single-beat AXI4 master.
// One transaction at a time. Responses are passed back in the same
// cycle as the R/B handshake.
//
// state | meaning
// IDLE  | waiting for a core request; grant is combinational
// AR    | read address presented, waiting for arready
// R     | waiting for the read data beat
// WR    | AW and W presented, each dropped after its own handshake
// B     | waiting for the write response
module ibex_obi_axi_bridge #(
    parameter logic [0:0] AXI_ID    = 1'b0,
    parameter logic [3:0] AXI_CACHE = 4'b0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // OBI data port
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    // AXI4 write address
    output logic [0:0]  m_axi_awid_o,
    output logic [31:0] m_axi_awaddr_o,
    output logic [7:0]  m_axi_awlen_o,
    output logic [2:0]  m_axi_awsize_o,
    output logic [1:0]  m_axi_awburst_o,
    output logic        m_axi_awlock_o,
    output logic [3:0]  m_axi_awcache_o,
    output logic [2:0]  m_axi_awprot_o,
    output logic [3:0]  m_axi_awqos_o,
    output logic        m_axi_awvalid_o,
    input  logic        m_axi_awready_i,
    // AXI4 write data
    output logic [31:0] m_axi_wdata_o,
    output logic [3:0]  m_axi_wstrb_o,
    output logic        m_axi_wlast_o,
    output logic        m_axi_wvalid_o,
    input  logic        m_axi_wready_i,
    // AXI4 write response
    input  logic [0:0]  m_axi_bid_i,
    input  logic [1:0]  m_axi_bresp_i,
    input  logic        m_axi_bvalid_i,
    output logic        m_axi_bready_o,
    // AXI4 read address
    output logic [0:0]  m_axi_arid_o,
    output logic [31:0] m_axi_araddr_o,
    output logic [7:0]  m_axi_arlen_o,
    output logic [2:0]  m_axi_arsize_o,
    output logic [1:0]  m_axi_arburst_o,
    output logic        m_axi_arlock_o,
    output logic [3:0]  m_axi_arcache_o,
    output logic [2:0]  m_axi_arprot_o,
    output logic [3:0]  m_axi_arqos_o,
    output logic        m_axi_arvalid_o,
    input  logic        m_axi_arready_i,
    // AXI4 read data
    input  logic [0:0]  m_axi_rid_i,
    input  logic [31:0] m_axi_rdata_i,
    input  logic [1:0]  m_axi_rresp_i,
    input  logic        m_axi_rlast_i,
    input  logic        m_axi_rvalid_i,
    output logic        m_axi_rready_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        WR   = 3'd3,
        B    = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    // Single-beat, word-sized, incrementing bursts with fixed attributes.
    assign m_axi_awid_o    = AXI_ID;
    assign m_axi_awaddr_o  = {addr_q[31:2], 2'b00};
    assign m_axi_awlen_o   = 8'd0;
    assign m_axi_awsize_o  = 3'b010;
    assign m_axi_awburst_o = 2'b01;
    assign m_axi_awlock_o  = 1'b0;
    assign m_axi_awcache_o = AXI_CACHE;
    assign m_axi_awprot_o  = 3'b000;
    assign m_axi_awqos_o   = 4'd0;
    assign m_axi_wdata_o   = wdata_q;
    assign m_axi_wstrb_o   = be_q;
    assign m_axi_wlast_o   = 1'b1;
    assign m_axi_arid_o    = AXI_ID;
    assign m_axi_araddr_o  = {addr_q[31:2], 2'b00};
    assign m_axi_arlen_o   = 8'd0;
    assign m_axi_arsize_o  = 3'b010;
    assign m_axi_arburst_o = 2'b01;
    assign m_axi_arlock_o  = 1'b0;
    assign m_axi_arcache_o = AXI_CACHE;
    assign m_axi_arprot_o  = 3'b000;
    assign m_axi_arqos_o   = 4'd0;

    // IDs and rlast carry no information for single-beat, single-outstanding use.
    logic unused_sig;
    assign unused_sig = ^{m_axi_bid_i, m_axi_rid_i, m_axi_rlast_i, m_axi_rresp_i[0],
                          m_axi_bresp_i[0], addr_q[1:0], we_q};

    // State register and request capture on grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (data_gnt_o) begin
                we_q    <= data_we_i;
                be_q    <= data_be_i;
                addr_q  <= data_addr_i;
                wdata_q <= data_wdata_i;
            end
        end
    end

    // Next state and handshake outputs; everything is forced low while in reset.
    always_comb begin
        state_d         = state_q;
        aw_done_d       = aw_done_q;
        w_done_d        = w_done_q;
        data_gnt_o      = 1'b0;
        data_rvalid_o   = 1'b0;
        data_rdata_o    = 32'd0;
        data_err_o      = 1'b0;
        m_axi_arvalid_o = 1'b0;
        m_axi_rready_o  = 1'b0;
        m_axi_awvalid_o = 1'b0;
        m_axi_wvalid_o  = 1'b0;
        m_axi_bready_o  = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                IDLE: begin
                    if (data_req_i) begin
                        data_gnt_o = 1'b1;
                        state_d    = data_we_i ? WR : AR;
                    end
                end
                AR: begin
                    m_axi_arvalid_o = 1'b1;
                    if (m_axi_arready_i) state_d = R;
                end
                R: begin
                    m_axi_rready_o = 1'b1;
                    if (m_axi_rvalid_i) begin
                        data_rvalid_o = 1'b1;
                        data_rdata_o  = m_axi_rdata_i;
                        data_err_o    = m_axi_rresp_i[1];
                        state_d       = IDLE;
                    end
                end
                WR: begin
                    m_axi_awvalid_o = !aw_done_q;
                    m_axi_wvalid_o  = !w_done_q;
                    aw_done_d = aw_done_q | m_axi_awready_i;
                    w_done_d  = w_done_q | m_axi_wready_i;
                    if (aw_done_d && w_done_d) begin
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = B;
                    end
                end
                B: begin
                    m_axi_bready_o = 1'b1;
                    if (m_axi_bvalid_i) begin
                        data_rvalid_o = 1'b1;
                        data_err_o    = m_axi_bresp_i[1];
                        state_d       = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_obi_axi_bridge.sv
// Directed bench for ibex_obi_axi_bridge: inputs change 1 ns after the
// rising edge, outputs are checked 1 ns later, well before the next edge.
module tb_ibex_obi_axi_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        data_req_i, data_gnt_o, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic [0:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awlock, arlock, wlast, rlast;
    logic [3:0]  awcache, arcache, awqos, arqos, wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;

    int passed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    ibex_obi_axi_bridge dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .m_axi_awid_o(awid), .m_axi_awaddr_o(awaddr), .m_axi_awlen_o(awlen),
        .m_axi_awsize_o(awsize), .m_axi_awburst_o(awburst), .m_axi_awlock_o(awlock),
        .m_axi_awcache_o(awcache), .m_axi_awprot_o(awprot), .m_axi_awqos_o(awqos),
        .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
        .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
        .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
        .m_axi_bid_i(bid), .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid),
        .m_axi_bready_o(bready),
        .m_axi_arid_o(arid), .m_axi_araddr_o(araddr), .m_axi_arlen_o(arlen),
        .m_axi_arsize_o(arsize), .m_axi_arburst_o(arburst), .m_axi_arlock_o(arlock),
        .m_axi_arcache_o(arcache), .m_axi_arprot_o(arprot), .m_axi_arqos_o(arqos),
        .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
        .m_axi_rid_i(rid), .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp),
        .m_axi_rlast_i(rlast), .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        data_req_i = 0; data_we_i = 0; data_be_i = 4'hF;
        data_addr_i = 0; data_wdata_i = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 1'b1;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rid = 1'b1; rlast = 0;

        // reset: everything low, no grant even with a request present
        nxt(); nxt();
        data_req_i = 1;
        #1;
        chk("rst_gnt", data_gnt_o, 0);
        chk("rst_rvalid", data_rvalid_o, 0);
        chk("rst_rdata", data_rdata_o, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);

        // read, unaligned address, rvalid two cycles after AR handshake
        nxt();
        rst_i = 0; data_we_i = 0; data_addr_i = 32'h1000_0006;
        #1;
        chk("rd_gnt", data_gnt_o, 1);
        chk("rd_arvalid_n", arvalid, 0);
        nxt();
        data_req_i = 0; arready = 1;
        #1;
        chk("rd_arvalid", arvalid, 1);
        chk("rd_araddr", araddr, 32'h1000_0004);
        chk("rd_arlen", arlen, 0);
        chk("rd_arsize", arsize, 3'b010);
        chk("rd_arburst", arburst, 2'b01);
        chk("rd_arid", arid, 0);
        chk("rd_arcache", arcache, 0);
        nxt();
        arready = 0;
        #1;
        chk("rd_rready", rready, 1);
        chk("rd_arvalid_off", arvalid, 0);
        chk("rd_rvalid_early", data_rvalid_o, 0);
        nxt();
        rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b00; rlast = 1;
        #1;
        chk("rd_rvalid", data_rvalid_o, 1);
        chk("rd_rdata", data_rdata_o, 32'hDEAD_BEEF);
        chk("rd_err", data_err_o, 0);
        nxt();
        rvalid = 0;
        #1;
        chk("rd_rvalid_once", data_rvalid_o, 0);
        chk("rd_rready_off", rready, 0);

        // write with AW accepted in cycle 1 and W in cycle 3
        data_req_i = 1; data_we_i = 1; data_be_i = 4'b0011;
        data_wdata_i = 32'h1234_5678; data_addr_i = 32'h2000_0008;
        #1;
        chk("wr_gnt", data_gnt_o, 1);
        nxt();
        data_req_i = 0; awready = 1; wready = 0;
        #1;
        chk("wr_c1_awvalid", awvalid, 1);
        chk("wr_c1_wvalid", wvalid, 1);
        chk("wr_awaddr", awaddr, 32'h2000_0008);
        chk("wr_wdata", wdata, 32'h1234_5678);
        chk("wr_wstrb", wstrb, 4'b0011);
        chk("wr_wlast", wlast, 1);
        chk("wr_awlen", awlen, 0);
        chk("wr_awsize", awsize, 3'b010);
        nxt();
        awready = 0;
        #1;
        chk("wr_c2_awvalid", awvalid, 0);
        chk("wr_c2_wvalid", wvalid, 1);
        chk("wr_c2_wstrb", wstrb, 4'b0011);
        nxt();
        wready = 1;
        #1;
        chk("wr_c3_wvalid", wvalid, 1);
        chk("wr_c3_wdata", wdata, 32'h1234_5678);
        chk("wr_c3_bready", bready, 0);
        nxt();
        wready = 0; bvalid = 1; bresp = 2'b00;
        #1;
        chk("wr_b_bready", bready, 1);
        chk("wr_b_wvalid", wvalid, 0);
        chk("wr_b_rvalid", data_rvalid_o, 1);
        chk("wr_b_err", data_err_o, 0);
        chk("wr_b_rdata", data_rdata_o, 0);
        nxt();
        bvalid = 0;

        // simultaneous AW/W, DECERR, then back-to-back read with SLVERR
        data_req_i = 1; data_we_i = 1; data_be_i = 4'hF;
        data_wdata_i = 32'hA5A5_A5A5; data_addr_i = 32'h3000_0000;
        #1;
        chk("sim_gnt", data_gnt_o, 1);
        nxt();
        data_req_i = 0; awready = 1; wready = 1;
        #1;
        chk("sim_awvalid", awvalid, 1);
        chk("sim_wvalid", wvalid, 1);
        nxt();
        awready = 0; wready = 0; bvalid = 1; bresp = 2'b11;
        data_req_i = 1; data_we_i = 0; data_addr_i = 32'h4000_0000;
        #1;
        chk("sim_bready", bready, 1);
        chk("sim_rvalid", data_rvalid_o, 1);
        chk("decerr_err", data_err_o, 1);
        chk("b2b_gnt_busy", data_gnt_o, 0);
        nxt();
        bvalid = 0;
        #1;
        chk("b2b_gnt", data_gnt_o, 1);
        nxt();
        data_req_i = 0; arready = 1;
        #1;
        chk("b2b_arvalid", arvalid, 1);
        chk("b2b_araddr", araddr, 32'h4000_0000);
        nxt();
        arready = 0; rvalid = 1; rresp = 2'b10; rdata = 32'h1111_2222;
        #1;
        chk("slverr_rvalid", data_rvalid_o, 1);
        chk("slverr_err", data_err_o, 1);
        chk("slverr_rdata", data_rdata_o, 32'h1111_2222);
        nxt();
        rvalid = 0; rresp = 2'b00;

        // arready backpressure for 5 cycles with a competing request
        data_req_i = 1; data_we_i = 0; data_addr_i = 32'h5000_000F;
        #1;
        chk("bp_gnt", data_gnt_o, 1);
        nxt();
        data_addr_i = 32'h9999_9990;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_arvalid_%0d", i), arvalid, 1);
            chk($sformatf("bp_araddr_%0d", i), araddr, 32'h5000_000C);
            chk($sformatf("bp_gnt_%0d", i), data_gnt_o, 0);
            nxt();
        end
        data_req_i = 0; arready = 1;
        #1;
        chk("bp_final_araddr", araddr, 32'h5000_000C);
        nxt();
        arready = 0;
        #1;
        chk("bp_rready", rready, 1);

        // reset while waiting for read data
        nxt();
        rst_i = 1;
        nxt();
        rst_i = 0; rvalid = 1; rdata = 32'h7777_7777;
        data_req_i = 1; data_we_i = 0; data_addr_i = 32'h6000_0000;
        #1;
        chk("rstr_rready", rready, 0);
        chk("rstr_rvalid", data_rvalid_o, 0);
        chk("rstr_gnt", data_gnt_o, 1);
        nxt();
        rvalid = 0; data_req_i = 0; arready = 1;
        #1;
        chk("rstr_arvalid", arvalid, 1);
        chk("rstr_araddr", araddr, 32'h6000_0000);
        nxt();
        arready = 0; rvalid = 1; rdata = 32'hCAFE_F00D;
        #1;
        chk("rstr_rd_rvalid", data_rvalid_o, 1);
        chk("rstr_rd_rdata", data_rdata_o, 32'hCAFE_F00D);
        nxt();
        rvalid = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ibex_obi_axi_bridge.md
IBEX_OBI_AXI_BRIDGE -- requirements
Module: ibex_obi_axi_bridge

Interface
REQ-001 SHALL have parameter AXI_ID, default 0, the constant ID driven on AW/AR.
REQ-002 SHALL have parameter AXI_CACHE, default 4'b0000, the constant driven on awcache/arcache.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port data_req_i, input, 1 bit: core request valid.
REQ-006 SHALL have port data_gnt_o, output, 1 bit: request accepted.
REQ-007 SHALL have port data_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port data_be_i, input, 4 bits: byte enables.
REQ-009 SHALL have port data_addr_i, input, 32 bits: byte address.
REQ-010 SHALL have port data_wdata_i, input, 32 bits: write data.
REQ-011 SHALL have port data_rvalid_o, output, 1 bit: response valid, one-cycle pulse.
REQ-012 SHALL have port data_rdata_o, output, 32 bits: read data.
REQ-013 SHALL have port data_err_o, output, 1 bit: bus error flag qualified by data_rvalid_o.
REQ-014 SHALL have a flattened AXI4 master port set m_axi_{aw*,w*,b*,ar*,r*}, with 32-bit address/data and 1-bit ID, directions per AXI4; user signals omitted.

Function
REQ-015 SHALL implement FSM states IDLE, AR, R, WR, B; only one transaction outstanding.
REQ-016 SHALL assert data_gnt_o combinationally iff state==IDLE && data_req_i && !rst_i; on grant, register we/be/addr/wdata.
REQ-017 SHALL transition on grant from IDLE to AR when we=0, or to WR when we=1.
REQ-018 AR state: SHALL drive arvalid=1 with araddr={addr[31:2],2'b00}; on arready go to R.
REQ-019 R state: SHALL drive rready=1; on rvalid pulse data_rvalid_o, drive rdata_o=rdata and err_o=rresp[1], then go to IDLE.
REQ-020 WR state: SHALL drive awvalid and wvalid=1 from the first WR cycle, deassert each independently after its own handshake, and go to B in the cycle both have completed (the same cycle, if both complete simultaneously).
REQ-021 W beat: SHALL drive wdata=registered wdata, wstrb=registered be, wlast=1.
REQ-022 B state: SHALL drive bready=1; on bvalid pulse data_rvalid_o with err_o=bresp[1] and rdata_o=0, then go to IDLE.
REQ-023 SHALL drive constant fields: len=0, size=3'b010, burst=2'b01, lock=0, prot=3'b000, qos=0, cache=AXI_CACHE, id=AXI_ID.
REQ-024 Latency: grant in cycle N SHALL give arvalid/awvalid in cycle N+1; the response SHALL appear in the cycle of the r/b handshake, with no extra register stage.
REQ-025 A new grant SHALL be possible in the cycle after data_rvalid_o, giving a minimum 3-cycle period for a zero-wait-state slave.
REQ-026 SHALL hold all valid-qualified AXI payloads stable while their valid is high and unacknowledged.
REQ-027 SHALL ignore rid/bid; rlast SHALL be ignored because len=0.

Reset
REQ-028 On rst_i=1 at a clock edge, SHALL enter IDLE and clear the registered request.
REQ-029 In reset, all valid/ready outputs and data_gnt_o/data_rvalid_o/data_err_o SHALL be 0, and data_rdata_o SHALL be 0.
REQ-030 Reset mid-transaction SHALL abandon the transaction with no data_rvalid_o; outputs are 0 from the cycle after the reset edge.

Verification
REQ-031 Read: req, we=0, addr=0x1000_0006; arready=1 immediately; rvalid 2 cycles later with rdata=0xDEADBEEF, rresp=0 -> araddr=0x1000_0004, one rvalid_o pulse, rdata_o=0xDEADBEEF, err_o=0.
REQ-032 Write with skew: we=1, be=4'b0011, wdata=0x12345678; awready in cycle 1, wready in cycle 3 -> awvalid drops after cycle 1, wvalid held until cycle 3, wstrb=0011, wlast=1; bvalid with bresp=0 -> rvalid_o=1, err_o=0.
REQ-033 Simultaneous AW/W: awready=wready=1 in the first WR cycle -> B entered the next cycle; back-to-back req granted the cycle after rvalid_o.
REQ-034 Error: rresp=2'b10 (SLVERR) -> err_o=1; bresp=2'b11 (DECERR) -> err_o=1.
REQ-035 Backpressure: arready held 0 for 5 cycles -> arvalid and araddr stable throughout, data_gnt_o stays 0 for a second req.
REQ-036 Reset in R state before rvalid -> no data_rvalid_o, rready=0 the next cycle, FSM in IDLE, and a new req granted.
